mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory controller port between two CPU-side requesters: port 0 is instruction fetch, port 1 is data load/store.
- Round-robin arbitration, one outstanding access at a time, REQ/GNT/DONE handshake toward the requesters.
- Sequences the memory side with a one-cycle MEM_ENABLE strobe and waits for MEM_READY.
- Sits between the pipeline stages and the memory controller, in the CPU clock domain.

Parameters:
SIZE, 48, address/data width in bits
TIMEOUT, 64, WAIT-state cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
REQ  input  2  per-port request; bit i = port i
ADDR0  input  SIZE  port 0 address
ADDR1  input  SIZE  port 1 address
CTRL0  input  1  port 0 op: 0 = read, 1 = write
CTRL1  input  1  port 1 op: 0 = read, 1 = write
WDATA0  input  SIZE  port 0 write data
WDATA1  input  SIZE  port 1 write data
GNT  output  2  one-hot; request accepted (one cycle)
DONE  output  2  one-hot; access complete (one cycle)
RDATA  output  SIZE  read data; valid when DONE is high for a read
ERR  output  1  access timed out; valid with DONE
BUSY  output  1  high in any state except IDLE
STATE  output  2  current FSM state
MEM_ENABLE  output  1  memory access strobe
MEM_CTRL  output  1  latched op
MEM_ADDRESS  output  SIZE  latched address
MEM_WDATA  output  SIZE  latched write data
MEM_READ  input  SIZE  memory read data
MEM_READY  input  1  memory access complete

Behaviour:
- Reset (synchronous, RESET high at a rising edge):
  - STATE = IDLE.
  - GNT, DONE, ERR, BUSY, MEM_ENABLE = 0.
  - RDATA, MEM_ADDRESS, MEM_WDATA = 0; MEM_CTRL = 0.
  - Round-robin pointer LAST = 1, so port 0 wins the first tie.
  - Reset mid-access aborts the access: no DONE, and MEM_ENABLE is low from the next cycle.
- FSM encoding: IDLE = 00, ISSUE = 01, WAIT = 10, FIN = 11.
- IDLE:
  - If REQ != 0: select the winner, latch its ADDR/CTRL/WDATA into the MEM_* registers and the owner ID, then go to ISSUE.
  - Winner rule: the single requester if only one; if both, the port != LAST.
- ISSUE (exactly 1 cycle):
  - GNT[owner] = 1 and MEM_ENABLE = 1, then go to WAIT.
  - MEM_READY during ISSUE is ignored.
- WAIT:
  - MEM_ENABLE = 0; MEM_* address/ctrl/wdata held stable.
  - When MEM_READY = 1: if MEM_CTRL = 0, register MEM_READ into RDATA; go to FIN.
- FIN (1 cycle):
  - DONE[owner] = 1, LAST <= owner, go to IDLE.
- RDATA holds its value until the next completed read; writes leave it unchanged.
- Requester rules:
  - Hold REQ and its fields stable until GNT.
  - After GNT the fields are don't-care.
  - Next access is requested after DONE; REQ held high continuously means back-to-back requests.
- Latency:
  - REQ high at edge k gives ISSUE in cycle k+1 and WAIT in cycle k+2.
  - With MEM_READY in cycle k+2, DONE is in cycle k+3 (minimum 3 cycles).
  - Back-to-back: the next ISSUE follows FIN after one IDLE cycle, giving 4-cycle throughput per access.
- Fairness: under continuous REQ = 11, grants alternate 0,1,0,1...
- A request that drops before GNT while in IDLE is not served.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with MEM_READY still low: go to FIN with ERR = 1 alongside DONE[owner]; RDATA unchanged.
  - ERR = 0 on every other cycle.
- Undefined: WAIT persists until MEM_READY; ERR is tied to 0; no counter logic is present.

Test Plan:
- Reset, then REQ = 01, ADDR0 = 48'h10, CTRL0 = 0, MEM_READY = 1 at the cycle after MEM_ENABLE, MEM_READ = 48'hABC -> GNT = 01 and MEM_ENABLE for 1 cycle, MEM_ADDRESS = 48'h10, DONE = 01 three cycles after REQ, RDATA = 48'hABC.
- REQ = 11 held for 4 accesses, memory answers in 1 cycle -> GNT sequence 01,10,01,10; each DONE one-hot matches its GNT owner.
- Port 1 write, ADDR1 = 48'h20, WDATA1 = 48'h55, CTRL1 = 1 -> MEM_CTRL = 1, MEM_WDATA = 48'h55; RDATA keeps its previous value 48'hABC.
- MEM_READY delayed 5 cycles -> BUSY high and MEM_ADDRESS stable throughout WAIT; no DONE until the cycle after MEM_READY.
- RESET asserted during WAIT -> next cycle STATE = 00, all outputs 0, no DONE; first request after reset goes to port 0 when REQ = 11.
- MEM_TIMEOUT_EN defined, TIMEOUT = 8, MEM_READY never asserted -> DONE[owner] and ERR high together 8 WAIT cycles after ISSUE; STATE returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory controller port
// between two CPU-side requesters (port 0 = instruction fetch, port 1 = data).
// One access is outstanding at a time. The requester side uses a
// REQ/GNT/DONE handshake. The memory side gets a one-cycle MEM_ENABLE strobe
// and then waits for MEM_READY.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   - WAIT is abandoned after TIMEOUT cycles without MEM_READY, and
//               ERR is raised alongside DONE.
//   Undefined - WAIT persists until MEM_READY, and ERR is tied to 0.
//
// Ports:
//   CLK, RESET          clock (rising edge) and synchronous active-high reset
//   REQ[1:0]            per-port request
//   ADDR0/1, CTRL0/1,   per-port address, op (0 = read, 1 = write) and write data
//   WDATA0/1
//   GNT[1:0]            one-hot request accepted (one cycle, in ISSUE)
//   DONE[1:0]           one-hot access complete (one cycle, in FIN)
//   RDATA               read data, updated only by completed reads
//   ERR                 access timed out, valid with DONE
//   BUSY, STATE         not-idle flag and current FSM state
//   MEM_ENABLE          access strobe toward the memory controller
//   MEM_CTRL            latched op
//   MEM_ADDRESS         latched address
//   MEM_WDATA           latched write data
//   MEM_READ            memory read data
//   MEM_READY           memory access complete
module mem_arbiter #(
  parameter int SIZE    = 48,
  parameter int TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [1:0]      REQ,
  input  logic [SIZE-1:0] ADDR0,
  input  logic [SIZE-1:0] ADDR1,
  input  logic            CTRL0,
  input  logic            CTRL1,
  input  logic [SIZE-1:0] WDATA0,
  input  logic [SIZE-1:0] WDATA1,
  output logic [1:0]      GNT,
  output logic [1:0]      DONE,
  output logic [SIZE-1:0] RDATA,
  output logic            ERR,
  output logic            BUSY,
  output logic [1:0]      STATE,
  output logic            MEM_ENABLE,
  output logic            MEM_CTRL,
  output logic [SIZE-1:0] MEM_ADDRESS,
  output logic [SIZE-1:0] MEM_WDATA,
  input  logic [SIZE-1:0] MEM_READ,
  input  logic            MEM_READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    FIN   = 2'b11
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic            win_s;
  logic            owner_r;
  logic            last_r;
  logic [1:0]      gnt_r;
  logic [1:0]      done_r;
  logic            busy_r;
  logic            en_r;
  logic            ctrl_r;
  logic [SIZE-1:0] addr_r;
  logic [SIZE-1:0] wdata_r;
  logic [SIZE-1:0] rdata_r;

  // Reject a timeout too short to leave at least one WAIT cycle.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 2");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_r;
  logic             tmo_s;
  logic             err_r;

  assign tmo_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // WAIT-cycle counter: held at zero outside WAIT, so it restarts on each entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Error flag: set only for the FIN cycle that follows a timeout.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == WAIT) && !MEM_READY && tmo_s;
    end
  end

  assign ERR = err_r;
`else
  assign ERR = 1'b0;
`endif

  // Winner selection: a lone requester wins; on a tie the port that did not
  // finish last wins.
  always_comb begin
    win_s = 1'b0;
    case (REQ)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_r;
      default: win_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (REQ != 2'b00) begin
          next_s = ISSUE;
        end else begin
          next_s = IDLE;
        end
      end
      ISSUE: next_s = WAIT;  // MEM_READY is deliberately ignored here
      WAIT: begin
        if (MEM_READY) begin
          next_s = FIN;
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_s) begin
          next_s = FIN;
`endif
        end else begin
          next_s = WAIT;
        end
      end
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Datapath and handshake registers. Strobes are computed one cycle ahead so
  // they are high exactly while the FSM sits in ISSUE or FIN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
      done_r  <= 2'b00;
      busy_r  <= 1'b0;
      en_r    <= 1'b0;
      ctrl_r  <= 1'b0;
      addr_r  <= {SIZE{1'b0}};
      wdata_r <= {SIZE{1'b0}};
      rdata_r <= {SIZE{1'b0}};
    end else begin
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      en_r   <= 1'b0;
      busy_r <= (next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (REQ != 2'b00) begin
            owner_r <= win_s;
            gnt_r   <= win_s ? 2'b10 : 2'b01;
            en_r    <= 1'b1;
            ctrl_r  <= win_s ? CTRL1  : CTRL0;
            addr_r  <= win_s ? ADDR1  : ADDR0;
            wdata_r <= win_s ? WDATA1 : WDATA0;
          end
        end
        WAIT: begin
          if (MEM_READY && !ctrl_r) begin
            rdata_r <= MEM_READ;
          end
          if (next_s == FIN) begin
            done_r <= owner_r ? 2'b10 : 2'b01;
          end
        end
        FIN:     last_r <= owner_r;
        default: ;
      endcase
    end
  end

  assign GNT         = gnt_r;
  assign DONE        = done_r;
  assign RDATA       = rdata_r;
  assign BUSY        = busy_r;
  assign STATE       = state_r;
  assign MEM_ENABLE  = en_r;
  assign MEM_CTRL    = ctrl_r;
  assign MEM_ADDRESS = addr_r;
  assign MEM_WDATA   = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs are driven 1 time unit after
// each rising edge and outputs are checked at that same point.
module tb_mem_arbiter;

  localparam int SIZE = 48;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [1:0]      REQ;
  logic [SIZE-1:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic            CTRL0, CTRL1;
  logic [1:0]      GNT, DONE, STATE;
  logic [SIZE-1:0] RDATA, MEM_ADDRESS, MEM_WDATA, MEM_READ;
  logic            ERR, BUSY, MEM_ENABLE, MEM_CTRL, MEM_READY;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.SIZE(SIZE), .TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .CTRL0(CTRL0), .CTRL1(CTRL1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .STATE(STATE), .MEM_ENABLE(MEM_ENABLE), .MEM_CTRL(MEM_CTRL),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WDATA(MEM_WDATA),
    .MEM_READ(MEM_READ), .MEM_READY(MEM_READY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_gnt;

    RESET = 1'b1; REQ = 2'b00;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    CTRL0 = 1'b0; CTRL1 = 1'b0; MEM_READ = '0; MEM_READY = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    chk("rst_state", 64'(STATE), 64'd0);
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_en", 64'(MEM_ENABLE), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_addr", 64'(MEM_ADDRESS), 64'd0);

    // Port 0 read, memory ready one cycle after the strobe
    REQ = 2'b01; ADDR0 = 48'h10; CTRL0 = 1'b0; MEM_READ = 48'hABC;
    tick();
    chk("t1_state_issue", 64'(STATE), 64'd1);
    chk("t1_gnt", 64'(GNT), 64'd1);
    chk("t1_en", 64'(MEM_ENABLE), 64'd1);
    chk("t1_addr", 64'(MEM_ADDRESS), 64'h10);
    chk("t1_busy", 64'(BUSY), 64'd1);
    REQ = 2'b00; MEM_READY = 1'b1;  // ready during ISSUE must be ignored
    tick();
    chk("t1_state_wait", 64'(STATE), 64'd2);
    chk("t1_en_low", 64'(MEM_ENABLE), 64'd0);
    chk("t1_gnt_low", 64'(GNT), 64'd0);
    chk("t1_done_early", 64'(DONE), 64'd0);
    tick();
    chk("t1_done", 64'(DONE), 64'd1);
    chk("t1_rdata", 64'(RDATA), 64'hABC);
    chk("t1_err", 64'(ERR), 64'd0);
    MEM_READY = 1'b0;
    tick();
    chk("t1_idle", 64'(STATE), 64'd0);
    chk("t1_done_low", 64'(DONE), 64'd0);
    chk("t1_busy_low", 64'(BUSY), 64'd0);

    // Port 1 write with memory ready delayed 5 cycles
    REQ = 2'b10; ADDR1 = 48'h20; WDATA1 = 48'h55; CTRL1 = 1'b1;
    tick();
    chk("t2_gnt", 64'(GNT), 64'd2);
    chk("t2_ctrl", 64'(MEM_CTRL), 64'd1);
    chk("t2_wdata", 64'(MEM_WDATA), 64'h55);
    chk("t2_addr", 64'(MEM_ADDRESS), 64'h20);
    REQ = 2'b00; ADDR1 = 48'hFFFF; WDATA1 = 48'h0; CTRL1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_wait_state", 64'(STATE), 64'd2);
      chk("t2_wait_busy", 64'(BUSY), 64'd1);
      chk("t2_wait_addr", 64'(MEM_ADDRESS), 64'h20);
      chk("t2_wait_done", 64'(DONE), 64'd0);
    end
    MEM_READY = 1'b1; MEM_READ = 48'h999;
    tick();
    chk("t2_done", 64'(DONE), 64'd2);
    chk("t2_rdata_kept", 64'(RDATA), 64'hABC);
    MEM_READY = 1'b0;
    tick();
    chk("t2_idle", 64'(STATE), 64'd0);

    // Fairness under continuous REQ = 11
    REQ = 2'b11; ADDR0 = 48'h100; ADDR1 = 48'h200;
    CTRL0 = 1'b0; CTRL1 = 1'b0; MEM_READY = 1'b1; MEM_READ = 48'h123;
    exp_gnt = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_gnt", 64'(GNT), 64'(exp_gnt));
      chk("t3_addr", 64'(MEM_ADDRESS), (exp_gnt == 2'b01) ? 64'h100 : 64'h200);
      tick();
      chk("t3_wait", 64'(STATE), 64'd2);
      tick();
      chk("t3_done", 64'(DONE), 64'(exp_gnt));
      tick();
      chk("t3_idle", 64'(STATE), 64'd0);
      exp_gnt = {exp_gnt[0], exp_gnt[1]};
    end
    chk("t3_rdata", 64'(RDATA), 64'h123);
    REQ = 2'b00; MEM_READY = 1'b0;

    // Port 0 access so the round-robin pointer ends at 0
    REQ = 2'b01;
    tick();
    chk("t4_gnt0", 64'(GNT), 64'd1);
    REQ = 2'b00; MEM_READY = 1'b1;
    tick(); tick();
    chk("t4_done0", 64'(DONE), 64'd1);
    MEM_READY = 1'b0;
    tick();

    // Reset during WAIT aborts the access and restores port 0 priority
    REQ = 2'b10;
    tick();
    chk("t4_gnt1", 64'(GNT), 64'd2);
    REQ = 2'b00;
    tick();
    chk("t4_wait", 64'(STATE), 64'd2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t4_rst_state", 64'(STATE), 64'd0);
    chk("t4_rst_done", 64'(DONE), 64'd0);
    chk("t4_rst_busy", 64'(BUSY), 64'd0);
    chk("t4_rst_en", 64'(MEM_ENABLE), 64'd0);
    chk("t4_rst_addr", 64'(MEM_ADDRESS), 64'd0);
    chk("t4_rst_rdata", 64'(RDATA), 64'd0);
    REQ = 2'b11;
    tick();
    chk("t4_first_gnt", 64'(GNT), 64'd1);
    REQ = 2'b00; MEM_READY = 1'b1;
    tick();
    chk("t4_no_done", 64'(DONE), 64'd0);
    tick();
    chk("t4_done", 64'(DONE), 64'd1);
    MEM_READY = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Timeout: memory never answers; FIN after 8 WAIT cycles
    REQ = 2'b01;
    tick();
    chk("t5_gnt", 64'(GNT), 64'd1);
    REQ = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_wait", 64'(STATE), 64'd2);
      chk("t5_err_low", 64'(ERR), 64'd0);
    end
    tick();
    chk("t5_done", 64'(DONE), 64'd1);
    chk("t5_err", 64'(ERR), 64'd1);
    chk("t5_rdata", 64'(RDATA), 64'h123);
    tick();
    chk("t5_idle", 64'(STATE), 64'd0);
    chk("t5_err_clr", 64'(ERR), 64'd0);
`else
    // Without the timeout feature a silent memory keeps the FSM in WAIT
    REQ = 2'b01;
    tick();
    REQ = 2'b00;
    for (int i = 0; i < 70; i++) tick();
    chk("t5_stuck_wait", 64'(STATE), 64'd2);
    chk("t5_err_tied", 64'(ERR), 64'd0);
    MEM_READY = 1'b1;
    tick();
    chk("t5_done", 64'(DONE), 64'd1);
    MEM_READY = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
